// File: rtl/control_unidad_pipe.sv
// Registered main control unit for the pipelined MIPS core (ID stage -> ID/EX control word).
// Optional load-use hazard detection and STALL state enabled by defining CONTROL_LOAD_USE_EN.
module control_unidad_pipe #(
  parameter int NB_OP        = 6,
  parameter int NB_REG       = 5,
  parameter int NB_ALUOP     = 2,
  parameter int STALL_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_Enable,
  input  logic                i_Valid,
  input  logic [NB_OP-1:0]    i_Opcode,
  input  logic [NB_REG-1:0]   i_Rs,
  input  logic [NB_REG-1:0]   i_Rt,
  input  logic                i_Flush,
  output logic                o_RegDst,
  output logic                o_Jump,
  output logic                o_Branch,
  output logic                o_MemRead,
  output logic                o_MemToReg,
  output logic                o_MemWrite,
  output logic                o_ALUSrc,
  output logic                o_RegWrite,
  output logic                o_ExtensionMode,
  output logic [NB_ALUOP-1:0] o_ALUOp,
  output logic                o_Valid,
  output logic [NB_REG-1:0]   o_RtEx,
  output logic                o_Stall,
  output logic                o_Halt
);

  localparam logic [NB_OP-1:0] OP_BAS  = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_ADDI = NB_OP'(6'b001000);
  localparam logic [NB_OP-1:0] OP_ANDI = NB_OP'(6'b001100);
  localparam logic [NB_OP-1:0] OP_SLTI = NB_OP'(6'b001010);
  localparam logic [NB_OP-1:0] OP_LW   = NB_OP'(6'b100011);
  localparam logic [NB_OP-1:0] OP_SW   = NB_OP'(6'b101011);
  localparam logic [NB_OP-1:0] OP_BEQ  = NB_OP'(6'b000100);
  localparam logic [NB_OP-1:0] OP_J    = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_HALT = NB_OP'(6'b111111);

  typedef struct packed {
    logic                reg_dst;
    logic                jump;
    logic                branch;
    logic                mem_read;
    logic                mem_to_reg;
    logic                mem_write;
    logic                alu_src;
    logic                reg_write;
    logic                ext_mode;
    logic [NB_ALUOP-1:0] alu_op;
  } ctrl_t;

`ifdef CONTROL_LOAD_USE_EN
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALTED = 2'd2} state_t;
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
`else
  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd2} state_t;
`endif

  function automatic ctrl_t decode(input logic [NB_OP-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_BAS:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = NB_ALUOP'(2'b10); end
      OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_ANDI: begin
        c.alu_src = 1'b1; c.reg_write = 1'b1; c.ext_mode = 1'b1; c.alu_op = NB_ALUOP'(2'b11);
      end
      OP_SLTI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = NB_ALUOP'(2'b11); end
      OP_LW:   begin
        c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
      end
      OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BEQ:  begin c.branch = 1'b1; c.alu_op = NB_ALUOP'(2'b01); end
      OP_J:    c.jump = 1'b1;
      OP_HALT: c = '0;
      default: c.alu_op = NB_ALUOP'(2'b11);
    endcase
    return c;
  endfunction

  state_t              state;
  ctrl_t               ctrl_p0;
  logic                vld_p0;
  logic [NB_REG-1:0]   rt_p0;
  logic                halt_p0;
  logic                is_halt;
  logic                hazard;

  assign is_halt = i_Valid && (i_Opcode == OP_HALT);

`ifdef CONTROL_LOAD_USE_EN
  logic [CNT_W-1:0] cnt_p0;
  logic             rt_is_src;

  // Rt is only a source operand for R-type, store and branch
  assign rt_is_src = (i_Opcode == OP_BAS) || (i_Opcode == OP_SW) || (i_Opcode == OP_BEQ);
  assign hazard = (state == RUN) && i_Valid && vld_p0 && ctrl_p0.mem_read &&
                  (rt_p0 != '0) && ((rt_p0 == i_Rs) || ((rt_p0 == i_Rt) && rt_is_src));

  always_comb begin
    o_Stall = 1'b0;
    case (state)
      RUN:     o_Stall = hazard && !i_Flush && !is_halt;
      STALL:   o_Stall = !i_Flush;
      HALTED:  o_Stall = 1'b1;
      default: o_Stall = 1'b0;
    endcase
  end
`else
  logic unused_rs;
  assign unused_rs = ^i_Rs;
  assign hazard    = 1'b0;
  assign o_Stall   = (state == HALTED);
`endif

  // ID -> ID/EX register stage
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= RUN;
      ctrl_p0 <= '0;
      vld_p0  <= 1'b0;
      rt_p0   <= '0;
      halt_p0 <= 1'b0;
`ifdef CONTROL_LOAD_USE_EN
      cnt_p0  <= '0;
`endif
    end else if (i_Enable) begin
      case (state)
        RUN: begin
          if (i_Flush) begin
            ctrl_p0 <= '0;
            vld_p0  <= 1'b0;
          end else if (is_halt) begin
            ctrl_p0 <= '0;
            vld_p0  <= 1'b0;
            halt_p0 <= 1'b1;
            state   <= HALTED;
          end else if (hazard) begin
            ctrl_p0 <= '0;
            vld_p0  <= 1'b0;
`ifdef CONTROL_LOAD_USE_EN
            if (STALL_CYCLES > 1) begin
              cnt_p0 <= CNT_W'(STALL_CYCLES - 1);
              state  <= STALL;
            end
`endif
          end else begin
            ctrl_p0 <= i_Valid ? decode(i_Opcode) : '0;
            vld_p0  <= i_Valid;
            rt_p0   <= i_Rt;
          end
        end
`ifdef CONTROL_LOAD_USE_EN
        STALL: begin
          ctrl_p0 <= '0;
          vld_p0  <= 1'b0;
          if (i_Flush || (cnt_p0 <= CNT_W'(1))) begin
            cnt_p0 <= '0;
            state  <= RUN;
          end else begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
          end
        end
`endif
        HALTED: begin
          ctrl_p0 <= '0;
          vld_p0  <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign o_RegDst        = ctrl_p0.reg_dst;
  assign o_Jump          = ctrl_p0.jump;
  assign o_Branch        = ctrl_p0.branch;
  assign o_MemRead       = ctrl_p0.mem_read;
  assign o_MemToReg      = ctrl_p0.mem_to_reg;
  assign o_MemWrite      = ctrl_p0.mem_write;
  assign o_ALUSrc        = ctrl_p0.alu_src;
  assign o_RegWrite      = ctrl_p0.reg_write;
  assign o_ExtensionMode = ctrl_p0.ext_mode;
  assign o_ALUOp         = ctrl_p0.alu_op;
  assign o_Valid         = vld_p0;
  assign o_RtEx          = rt_p0;
  assign o_Halt          = halt_p0;

endmodule

// File: tb/tb_control_unidad_pipe.sv
// Directed bench for control_unidad_pipe: decode table vectors plus stall, flush, halt and reset sequences.
// Expectations track whether CONTROL_LOAD_USE_EN is defined for the build.
module tb_control_unidad_pipe;

  localparam logic [5:0] BAS = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100, SLTI = 6'b001010;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] HALT = 6'b111111, UNK = 6'b110000;

  // {RegDst,Jump,Branch,MemRead,MemToReg,MemWrite,ALUSrc,RegWrite,ExtMode,ALUOp[1:0]}
  localparam logic [10:0] W_BUB  = {9'b000000000, 2'b00};
  localparam logic [10:0] W_BAS  = {9'b100000010, 2'b10};
  localparam logic [10:0] W_ADDI = {9'b000000110, 2'b00};
  localparam logic [10:0] W_ANDI = {9'b000000111, 2'b11};
  localparam logic [10:0] W_SLTI = {9'b000000110, 2'b11};
  localparam logic [10:0] W_LW   = {9'b000110110, 2'b00};
  localparam logic [10:0] W_SW   = {9'b000001100, 2'b00};
  localparam logic [10:0] W_BEQ  = {9'b001000000, 2'b01};
  localparam logic [10:0] W_J    = {9'b010000000, 2'b00};
  localparam logic [10:0] W_UNK  = {9'b000000000, 2'b11};

  logic       clk = 1'b0;
  logic       rst, en, vld, flush;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, ext_mode;
  logic [1:0] alu_op;
  logic       out_vld, stall, halt;
  logic [4:0] rt_ex;
  logic [10:0] word;

  int errors = 0;
  int checks = 0;

  control_unidad_pipe #(.NB_OP(6), .NB_REG(5), .NB_ALUOP(2), .STALL_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Valid(vld), .i_Opcode(op),
    .i_Rs(rs), .i_Rt(rt), .i_Flush(flush),
    .o_RegDst(reg_dst), .o_Jump(jump), .o_Branch(branch), .o_MemRead(mem_read),
    .o_MemToReg(mem_to_reg), .o_MemWrite(mem_write), .o_ALUSrc(alu_src),
    .o_RegWrite(reg_write), .o_ExtensionMode(ext_mode), .o_ALUOp(alu_op),
    .o_Valid(out_vld), .o_RtEx(rt_ex), .o_Stall(stall), .o_Halt(halt)
  );

  always #5 clk = ~clk;

  assign word = {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src,
                 reg_write, ext_mode, alu_op};

  typedef struct {
    logic        v;
    logic [5:0]  opc;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        fl;
    logic        e;
    logic        stall_x;
    logic [10:0] word_x;
    logic        vld_x;
    string       name;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v_i, input logic [5:0] o_i, input logic [4:0] s_i,
                              input logic [4:0] t_i, input logic f_i, input logic e_i,
                              input logic [10:0] w_i, input logic ov_i, input string n_i);
    vec_t r;
    r.v = v_i; r.opc = o_i; r.rs_a = s_i; r.rt_a = t_i; r.fl = f_i; r.e = e_i;
    r.stall_x = 1'b0; r.word_x = w_i; r.vld_x = ov_i; r.name = n_i;
    return r;
  endfunction

  task automatic drive(input logic v_i, input logic [5:0] o_i, input logic [4:0] s_i,
                       input logic [4:0] t_i, input logic f_i, input logic e_i);
    @(negedge clk);
    vld = v_i; op = o_i; rs = s_i; rt = t_i; flush = f_i; en = e_i;
  endtask

  task automatic chk_stall(input logic exp, input string name);
    #1;
    checks++;
    if (stall !== exp) begin
      errors++;
      $display("FAIL %s stall: got %b want %b", name, stall, exp);
    end
  endtask

  task automatic chk_out(input logic [10:0] wx, input logic vx, input logic hx, input string name);
    checks++;
    if (word !== wx) begin
      errors++;
      $display("FAIL %s word: got %b want %b", name, word, wx);
    end
    checks++;
    if (out_vld !== vx) begin
      errors++;
      $display("FAIL %s valid: got %b want %b", name, out_vld, vx);
    end
    checks++;
    if (halt !== hx) begin
      errors++;
      $display("FAIL %s halt: got %b want %b", name, halt, hx);
    end
  endtask

  task automatic tick(input logic [10:0] wx, input logic vx, input logic hx, input string name);
    @(posedge clk);
    #1;
    chk_out(wx, vx, hx, name);
  endtask

  initial begin
    tbl[0]  = mk(1, BAS,  5'd1, 5'd2, 0, 1, W_BAS,  1, "bas");
    tbl[1]  = mk(1, ANDI, 5'd1, 5'd2, 0, 1, W_ANDI, 1, "andi");
    tbl[2]  = mk(1, SW,   5'd1, 5'd2, 0, 1, W_SW,   1, "sw");
    tbl[3]  = mk(1, BEQ,  5'd1, 5'd2, 0, 1, W_BEQ,  1, "beq");
    tbl[4]  = mk(1, ADDI, 5'd1, 5'd2, 0, 1, W_ADDI, 1, "addi");
    tbl[5]  = mk(1, SLTI, 5'd1, 5'd2, 0, 1, W_SLTI, 1, "slti");
    tbl[6]  = mk(1, LW,   5'd1, 5'd3, 0, 1, W_LW,   1, "lw_rt3");
    tbl[7]  = mk(1, JMP,  5'd1, 5'd2, 0, 1, W_J,    1, "j");
    tbl[8]  = mk(1, UNK,  5'd1, 5'd2, 0, 1, W_UNK,  1, "unknown_op");
    tbl[9]  = mk(0, BAS,  5'd1, 5'd2, 0, 1, W_BUB,  0, "invalid_bubble");
    tbl[10] = mk(1, SW,   5'd1, 5'd2, 0, 1, W_SW,   1, "sw2");
    tbl[11] = mk(1, ADDI, 5'd1, 5'd2, 0, 0, W_SW,   1, "enable_hold");
    tbl[12] = mk(1, LW,   5'd1, 5'd0, 0, 1, W_LW,   1, "lw_rt0");
    tbl[13] = mk(1, BAS,  5'd0, 5'd0, 0, 1, W_BAS,  1, "rt0_no_stall");
    tbl[14] = mk(1, LW,   5'd2, 5'd7, 0, 1, W_LW,   1, "lw_rt7");
    tbl[15] = mk(1, ADDI, 5'd1, 5'd7, 0, 1, W_ADDI, 1, "addi_rt_not_src");
    tbl[16] = mk(0, HALT, 5'd1, 5'd2, 0, 1, W_BUB,  0, "halt_invalid");
    tbl[17] = mk(1, BAS,  5'd1, 5'd2, 1, 1, W_BUB,  0, "flush_normal");

    rst = 1'b1; en = 1'b1; vld = 1'b0; op = '0; rs = '0; rt = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out(W_BUB, 0, 0, "reset");
    chk_stall(1'b0, "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].opc, tbl[i].rs_a, tbl[i].rt_a, tbl[i].fl, tbl[i].e);
      chk_stall(tbl[i].stall_x, tbl[i].name);
      tick(tbl[i].word_x, tbl[i].vld_x, 1'b0, tbl[i].name);
    end

    // Load-use: LW rt=5 followed by R-type reading rs=5
    drive(1, LW, 5'd1, 5'd5, 0, 1);
    chk_stall(1'b0, "lu_lw");
    tick(W_LW, 1, 0, "lu_lw");
    drive(1, BAS, 5'd5, 5'd6, 0, 1);
`ifdef CONTROL_LOAD_USE_EN
    chk_stall(1'b1, "lu_stall1");
    tick(W_BUB, 0, 0, "lu_bubble1");
    chk_stall(1'b1, "lu_stall2");
    tick(W_BUB, 0, 0, "lu_bubble2");
    chk_stall(1'b0, "lu_release");
    tick(W_BAS, 1, 0, "lu_add");
`else
    chk_stall(1'b0, "lu_nostall");
    tick(W_BAS, 1, 0, "lu_add");
`endif

    // Enable held low for 3 cycles in the middle of a stall
    drive(1, LW, 5'd1, 5'd5, 0, 1);
    tick(W_LW, 1, 0, "fz_lw");
    drive(1, BAS, 5'd5, 5'd6, 0, 1);
`ifdef CONTROL_LOAD_USE_EN
    chk_stall(1'b1, "fz_stall_in");
    tick(W_BUB, 0, 0, "fz_bubble1");
    for (int k = 0; k < 3; k++) begin
      drive(1, BAS, 5'd5, 5'd6, 0, 0);
      chk_stall(1'b1, "fz_frozen_stall");
      tick(W_BUB, 0, 0, "fz_frozen");
    end
    drive(1, BAS, 5'd5, 5'd6, 0, 1);
    chk_stall(1'b1, "fz_stall_last");
    tick(W_BUB, 0, 0, "fz_bubble2");
    chk_stall(1'b0, "fz_release");
    tick(W_BAS, 1, 0, "fz_add");
`else
    chk_stall(1'b0, "fz_nostall");
    tick(W_BAS, 1, 0, "fz_add");
    for (int k = 0; k < 3; k++) begin
      drive(1, ADDI, 5'd1, 5'd2, 0, 0);
      chk_stall(1'b0, "fz_frozen_stall");
      tick(W_BAS, 1, 0, "fz_frozen");
    end
`endif

    // Flush in the same cycle as a load-use hazard
    drive(1, LW, 5'd1, 5'd5, 0, 1);
    tick(W_LW, 1, 0, "fh_lw");
    drive(1, BAS, 5'd5, 5'd6, 1, 1);
    chk_stall(1'b0, "fh_flush_stall");
    tick(W_BUB, 0, 0, "fh_flush");
    drive(1, BAS, 5'd5, 5'd6, 0, 1);
    chk_stall(1'b0, "fh_after_stall");
    tick(W_BAS, 1, 0, "fh_after");

    // Flush in the same cycle as HALT
    drive(1, HALT, 5'd1, 5'd2, 1, 1);
    chk_stall(1'b0, "fhalt_stall");
    tick(W_BUB, 0, 0, "fhalt_flush");
    drive(1, ADDI, 5'd1, 5'd2, 0, 1);
    tick(W_ADDI, 1, 0, "fhalt_after");

    // HALT is sticky, ignores flush, cleared only by reset
    drive(1, HALT, 5'd1, 5'd2, 0, 1);
    chk_stall(1'b0, "halt_pre");
    tick(W_BUB, 0, 1, "halt_enter");
    chk_stall(1'b1, "halt_stall");
    drive(1, BAS, 5'd1, 5'd2, 1, 1);
    chk_stall(1'b1, "halt_flush_stall");
    tick(W_BUB, 0, 1, "halt_flush_ignored");
    drive(1, BAS, 5'd1, 5'd2, 0, 1);
    tick(W_BUB, 0, 1, "halt_held");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out(W_BUB, 0, 0, "halt_async_reset");
    chk_stall(1'b0, "halt_async_reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1, BAS, 5'd1, 5'd2, 0, 1);
    chk_stall(1'b0, "post_reset");
    tick(W_BAS, 1, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unidad_pipe.md
Name: control_unidad_pipe

Overview:
Registered, parametrised main control unit for the pipelined MIPS core; sits between the IF/ID and ID/EX registers.
- Decodes the opcode into the ID/EX control word and registers it.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Accepts a flush from branch/jump resolution.
- Latches a HALT instruction into a sticky halted state for the debug unit.

Parameters:
NB_OP, 6, opcode width
NB_REG, 5, register-address width
NB_ALUOP, 2, ALUOp width (>=2; encodings below zero-extended)
STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_Enable  in  1  debug step enable; 0 freezes every register
i_Valid  in  1  IF/ID holds a valid instruction
i_Opcode  in  NB_OP  instruction[31:26]
i_Rs  in  NB_REG  instruction[25:21]
i_Rt  in  NB_REG  instruction[20:16]
i_Flush  in  1  squash the instruction currently in ID
o_RegDst, o_Jump, o_Branch, o_MemRead, o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite, o_ExtensionMode  out  1 each  registered ID/EX control
o_ALUOp  out  NB_ALUOP  registered ALU operation class
o_Valid  out  1  registered; ID/EX slot holds a real instruction
o_RtEx  out  NB_REG  registered i_Rt of the instruction in ID/EX
o_Stall  out  1  combinational; hold PC and IF/ID this cycle
o_Halt  out  1  registered; core halted

Behaviour:
- Reset: every output 0, o_ALUOp 0, state RUN, counter 0.
- Bubble: all control bits 0, o_ALUOp 0, o_Valid 0.
- Decode table (signals not listed are 0):
  - 000000 BAS: RegDst, RegWrite, ALUOp=10.
  - 001000 ADDI: ALUSrc, RegWrite, ALUOp=00.
  - 001100 ANDI: ALUSrc, RegWrite, ExtensionMode, ALUOp=11.
  - 001010 SLTI: ALUSrc, RegWrite, ALUOp=11.
  - 100011 LW: MemRead, MemToReg, ALUSrc, RegWrite, ALUOp=00.
  - 101011 SW: MemWrite, ALUSrc, ALUOp=00.
  - 000100 BEQ: Branch, ALUOp=01.
  - 000010 J: Jump, ALUOp=00.
  - 111111 HALT: no control bits; triggers HALTED.
  - Any other opcode: ALUOp=11, no control bits, o_Valid=1.
- Latency: one cycle from i_Opcode to the registered control word.
- Hazard (combinational): RUN & i_Valid & o_Valid & o_MemRead & o_RtEx!=0 & (o_RtEx==i_Rs | (o_RtEx==i_Rt & opcode in {BAS, SW, BEQ})).
- FSM RUN / STALL / HALTED. Per enabled edge, priority order: i_Flush > HALT > hazard > normal.
  - RUN, i_Flush=1: register bubble; stay RUN (cancels a same-cycle HALT or hazard).
  - RUN, valid HALT: register bubble, o_Halt<=1, go HALTED.
  - RUN, hazard: o_Stall=1, register bubble. If STALL_CYCLES>1: counter<=STALL_CYCLES-1, go STALL. Otherwise stay RUN.
  - RUN, normal: register the decoded word. o_Valid<=i_Valid; if i_Valid=0, register a bubble. o_RtEx<=i_Rt.
  - STALL, counter>1: o_Stall=1, bubble, counter decrements.
  - STALL, counter==1: o_Stall=1, bubble, counter<=0, go RUN; the held instruction decodes on the following edge.
  - STALL, i_Flush=1: bubble, counter<=0, go RUN.
  - HALTED: bubble every cycle, o_Stall=1, o_Halt=1; only reset exits (i_Flush ignored).
- o_Stall is 0 in RUN whenever i_Flush=1.
- i_Enable=0: no register, state or counter changes. o_Stall still reflects the current state and hazard.
- Reset asserted mid-stall or mid-halt: immediate return to the reset values.
- Counter width: $clog2(STALL_CYCLES+1).

Optional Feature:
Macro CONTROL_LOAD_USE_EN.
- Defined: hazard detection and the STALL state as specified.
- Undefined: hazard logic and counter removed, STALL state absent, o_Stall = (state==HALTED). Software or a forwarding unit must cover load-use.

Test Plan:
- Reset, then i_Valid=1 with 000000, 001100, 101011, 000100 on consecutive edges -> control words appear one cycle later, per the decode table (ANDI: ExtensionMode=1, ALUOp=11).
- LW with Rt=5, then ADD with Rs=5, STALL_CYCLES=2 -> o_Stall=1 for 2 cycles, 2 bubbles in ID/EX, then the ADD control word appears.
- LW with Rt=0, then ADD with Rs=0 -> no stall.
- LW Rt=7, then ADDI Rt=7 (Rt not a source) -> no stall.
- i_Flush=1 in the same cycle as a hazard, and separately in the same cycle as HALT -> bubble registered, o_Stall=0, o_Halt stays 0.
- HALT decoded -> o_Halt=1 next cycle and o_Stall=1 held; i_Flush ignored. Assert i_reset mid-halt -> all outputs 0 immediately.
- i_Enable=0 for 3 cycles during STALL -> counter and outputs frozen; on re-enable, the stall completes with the correct bubble count.
